// File: rtl/rs_queue.sv
// rs_queue: age-ordered reservation station with dual dispatch, dual CDB wakeup and single issue.
// Ports:
//   clk, rst (async active-low), recover (sync flush)
//   slot 1/2 dispatch: valid, res_en, resnum, rs/rt/rd phys tags, rd_en, fucontrol, imm, rs/rt data + ready flags
//   cdb1/cdb2: valid, tag, data result broadcasts
//   iss_ready in; iss_valid, iss_fucontrol, iss_imm, iss_rs_data, iss_rt_data, iss_rdp, iss_rd_en out
//   rs_stall (fewer than two free entries), rs_count (occupied entries)
module rs_queue #(
    parameter logic [1:0] RS_ID = 2'd0,
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        recover,
    input  logic        valid1dis,
    input  logic        res_en1dis,
    input  logic [1:0]  resnum1dis,
    input  logic [5:0]  rs1pdis,
    input  logic [5:0]  rt1pdis,
    input  logic [5:0]  rd1pdis,
    input  logic        rd1_endis,
    input  logic [3:0]  fucontrol1dis,
    input  logic [31:0] imm1dis,
    input  logic [31:0] rs1_datadis,
    input  logic [31:0] rt1_datadis,
    input  logic        rs1_dendis,
    input  logic        rt1_dendis,
    input  logic        valid2dis,
    input  logic        res_en2dis,
    input  logic [1:0]  resnum2dis,
    input  logic [5:0]  rs2pdis,
    input  logic [5:0]  rt2pdis,
    input  logic [5:0]  rd2pdis,
    input  logic        rd2_endis,
    input  logic [3:0]  fucontrol2dis,
    input  logic [31:0] imm2dis,
    input  logic [31:0] rs2_datadis,
    input  logic [31:0] rt2_datadis,
    input  logic        rs2_dendis,
    input  logic        rt2_dendis,
    input  logic        cdb1_valid,
    input  logic [5:0]  cdb1_tag,
    input  logic [31:0] cdb1_data,
    input  logic        cdb2_valid,
    input  logic [5:0]  cdb2_tag,
    input  logic [31:0] cdb2_data,
    input  logic        iss_ready,
    output logic        iss_valid,
    output logic [3:0]  iss_fucontrol,
    output logic [31:0] iss_imm,
    output logic [31:0] iss_rs_data,
    output logic [31:0] iss_rt_data,
    output logic [5:0]  iss_rdp,
    output logic        iss_rd_en,
    output logic        rs_stall,
    output logic [2:0]  rs_count
);
    localparam int IW = $clog2(DEPTH);

    typedef struct packed {
        logic [3:0]  fuc;
        logic [31:0] imm;
        logic [5:0]  rsp;
        logic [5:0]  rtp;
        logic [5:0]  rdp;
        logic        rd_en;
        logic [31:0] rsd;
        logic [31:0] rtd;
        logic        rsv;
        logic        rtv;
    } ent_t;

    ent_t          e_q [DEPTH];
    ent_t          e_d [DEPTH];
    ent_t          wk  [DEPTH];
    ent_t          n1, n2;
    logic [2:0]    cnt_q, cnt_d, n;
    logic          hold_q, hold_d;
    logic [IW-1:0] hidx_q, hidx_d, sel;
    logic          found, fire, acc1, acc2;

    // cdb1 takes priority when both buses carry the awaited tag
    function automatic ent_t wake(input ent_t e);
        ent_t w;
        w = e;
        if (!w.rsv && cdb1_valid && cdb1_tag == w.rsp) begin
            w.rsd = cdb1_data;
            w.rsv = 1'b1;
        end else if (!w.rsv && cdb2_valid && cdb2_tag == w.rsp) begin
            w.rsd = cdb2_data;
            w.rsv = 1'b1;
        end
        if (!w.rtv && cdb1_valid && cdb1_tag == w.rtp) begin
            w.rtd = cdb1_data;
            w.rtv = 1'b1;
        end else if (!w.rtv && cdb2_valid && cdb2_tag == w.rtp) begin
            w.rtd = cdb2_data;
            w.rtv = 1'b1;
        end
        return w;
    endfunction

    assign acc1 = valid1dis & res_en1dis & (resnum1dis == RS_ID);
    assign acc2 = valid2dis & res_en2dis & (resnum2dis == RS_ID);

    always_comb begin
        n1 = wake('{fucontrol1dis, imm1dis, rs1pdis, rt1pdis, rd1pdis, rd1_endis,
                    rs1_datadis, rt1_datadis, rs1_dendis, rt1_dendis});
        n2 = wake('{fucontrol2dis, imm2dis, rs2pdis, rt2pdis, rd2pdis, rd2_endis,
                    rs2_datadis, rt2_datadis, rs2_dendis, rt2_dendis});
    end

    // A stalled offer stays locked so a late-waking older entry cannot swap the fields under the FU
    always_comb begin
        found = hold_q;
        sel   = hidx_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (!found && 3'(i) < cnt_q && e_q[i].rsv && e_q[i].rtv) begin
                found = 1'b1;
                sel   = IW'(i);
            end
        end
    end

    assign iss_valid     = found & ~recover;
    assign fire          = iss_valid & iss_ready;
    assign iss_fucontrol = iss_valid ? e_q[sel].fuc   : '0;
    assign iss_imm       = iss_valid ? e_q[sel].imm   : '0;
    assign iss_rs_data   = iss_valid ? e_q[sel].rsd   : '0;
    assign iss_rt_data   = iss_valid ? e_q[sel].rtd   : '0;
    assign iss_rdp       = iss_valid ? e_q[sel].rdp   : '0;
    assign iss_rd_en     = iss_valid ? e_q[sel].rd_en : 1'b0;
    assign rs_count      = cnt_q;
    assign rs_stall      = cnt_q >= 3'(DEPTH - 1);

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            wk[i]  = wake(e_q[i]);
            e_d[i] = wk[i];
        end
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (fire && IW'(i) >= sel) e_d[i] = wk[i + 1];
        end
        n = cnt_q - {2'b0, fire};
        if (acc1 && n < 3'(DEPTH)) begin
            e_d[n[IW-1:0]] = n1;
            n = n + 3'd1;
        end
        if (acc2 && n < 3'(DEPTH)) begin
            e_d[n[IW-1:0]] = n2;
            n = n + 3'd1;
        end
        cnt_d  = recover ? 3'd0 : n;
        hold_d = iss_valid & ~iss_ready;
        hidx_d = sel;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            e_q    <= '{default: '0};
            cnt_q  <= 3'd0;
            hold_q <= 1'b0;
            hidx_q <= '0;
        end else begin
            e_q    <= e_d;
            cnt_q  <= cnt_d;
            hold_q <= hold_d;
            hidx_q <= hidx_d;
        end
    end
endmodule

// File: doc/rs_queue.md
RS_QUEUE -- requirements
Module: rs_queue

Interface
REQ-001 SHALL have parameter RS_ID, default 2'd0, the reservation-station number this instance answers to on resnum.
REQ-002 SHALL have parameter DEPTH, default 4, the number of entries; only 4 is required to be supported.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port recover  input  1  synchronous flush after branch mispredict.
REQ-006 SHALL have ports valid1dis/res_en1dis (1), resnum1dis (2), rs1pdis/rt1pdis/rd1pdis (6), rd1_endis (1), fucontrol1dis (4), imm1dis/rs1_datadis/rt1_datadis (32), rs1_dendis/rt1_dendis (1), all inputs, for dispatch slot 1.
REQ-007 SHALL have the identical input set with suffix 2 for dispatch slot 2; slot 1 is older than slot 2.
REQ-008 SHALL have ports cdb1_valid (1), cdb1_tag (6), cdb1_data (32), cdb2_valid, cdb2_tag, cdb2_data, all inputs: two result-broadcast buses.
REQ-009 SHALL have port iss_ready  input  1  FU accepts the offered instruction.
REQ-010 SHALL have ports iss_valid (1), iss_fucontrol (4), iss_imm/iss_rs_data/iss_rt_data (32), iss_rdp (6), iss_rd_en (1), all outputs: instruction offered to the FU.
REQ-011 SHALL have ports rs_stall  output  1 and rs_count  output  3 (occupied entries).

Function
REQ-012 Slot k SHALL be accepted when validkdis & res_enkdis & (resnumkdis == RS_ID).
REQ-013 Entries SHALL be held in age order (index 0 oldest); accepted slots append after existing entries, slot 1 before slot 2.
REQ-014 iss_valid SHALL be 1 when any entry has both operand-valid flags set, from registered state only (no same-cycle wakeup-to-issue).
REQ-015 The offered entry SHALL be the lowest-index (oldest) ready entry; iss_* fields SHALL be its stored fields.
REQ-016 On iss_valid & iss_ready the offered entry SHALL be removed at the clock edge and younger entries shift down by one; iss_* SHALL hold stable while iss_valid & !iss_ready.
REQ-017 Wakeup: for each stored operand with flag 0, a cdbN_valid with cdbN_tag equal to its physical number SHALL load cdbN_data and set the flag at the edge; cdb1 wins if both buses match.
REQ-018 Incoming dispatch operands with flag 0 SHALL be matched against the CDBs in the same cycle and written already woken.
REQ-019 Capacity after the edge SHALL be count - fire + accepted; acceptance uses space freed by a same-cycle issue.
REQ-020 rs_stall SHALL equal (rs_count >= DEPTH-1), i.e. fewer than two free entries, combinationally from registered count.
REQ-021 An accepted slot with no free entry SHALL be discarded with no state corruption (upstream must honour rs_stall).
REQ-022 recover SHALL clear all entries and count at the edge, override same-cycle acceptance and issue removal, and force iss_valid to 0 during its cycle.

Reset
REQ-023 While rst is 0: all entries invalid, rs_count=0, rs_stall=0, iss_valid=0, all other iss_* outputs 0; these values SHALL appear immediately, independent of clk.
REQ-024 First acceptance SHALL occur on the first rising edge after rst rises; reset mid-operation discards all entries.

Verification
REQ-025 Both slots RS_ID, all operands valid, iss_ready=1 -> next cycle iss_valid=1 with slot 1 fields; following cycle slot 2; rs_count 2->1->0.
REQ-026 Entry 0 rs waits on tag 6'd9, entry 1 ready -> entry 1 issues first; cdb1_valid tag 9 data 32'hDEAD -> entry 0 offers iss_rs_data=32'hDEAD one cycle later.
REQ-027 Slot 1 operand tag 6'd5 not ready while cdb2 broadcasts tag 5 data 32'h1234 same cycle -> entry stored ready, issues next cycle with 32'h1234.
REQ-028 Fill to 3 entries -> rs_stall=1; hold iss_ready=0 -> fields stable; iss_ready=1 with one slot accepted same cycle -> rs_count stays 3.
REQ-029 recover=1 with 4 entries and a concurrent dispatch -> next cycle rs_count=0, iss_valid=0; rst low mid-operation -> outputs 0 immediately.
